// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart_config block:
//   - parity mode constants (PARITY parameter values)
//   - state encodings used by both the TX and RX state machines
//   - receive status record and a parity helper
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // TX and RX walk through the same frame phases, so they share one encoding.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef struct packed {
      logic parity_err;
      logic frame_err;
      logic overrun;
   } rx_status_t;

   // Parity bit that makes the ones count of (data, parity) odd for
   // PARITY_ODD and even for PARITY_EVEN. Data is zero-extended to 9 bits.
   function automatic logic parity_bit(input logic [8:0] data, input int mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_config_if.sv
// ---------------------------------------------------------------------------
// uart_config_if
// Word-level handshake bundle of uart_config.
//   tx_valid/tx_ready/tx_data : word offered to the transmitter
//   rx_valid/rx_ready/rx_data : received word to the consumer
//   rx_parity_err/rx_frame_err/rx_overrun : status, qualified by rx_valid
//   tx_busy/rx_busy           : direction state machine not idle
// modport slave  : the UART side
// modport master : the user side
// ---------------------------------------------------------------------------
interface uart_config_if #(
   parameter int DATA_BITS = 8
);
   logic                 tx_valid;
   logic                 tx_ready;
   logic [DATA_BITS-1:0] tx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_parity_err;
   logic                 rx_frame_err;
   logic                 rx_overrun;
   logic                 tx_busy;
   logic                 rx_busy;

   modport slave (
      input  tx_valid, tx_data, rx_ready,
      output tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err,
             rx_overrun, tx_busy, rx_busy
   );

   modport master (
      output tx_valid, tx_data, rx_ready,
      input  tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err,
             rx_overrun, tx_busy, rx_busy
   );
endinterface

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Oversampling tick divider, one per direction.
//   clk, rst  : clock, asynchronous active-high reset
//   reload    : frame start; captures baud_div and restarts the count
//   baud_div  : tick period minus one, in clk cycles
//   tick      : one-cycle pulse every baud_div+1 cycles after reload
// ---------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reload,
   input  logic [DIV_W-1:0] baud_div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_reg;
   logic [DIV_W-1:0] div_reg;

   // The divisor is latched only on reload so a mid-frame change of
   // baud_div cannot stretch or shrink the frame in progress.
   assign tick = !reload && (cnt_reg == div_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
         div_reg <= '0;
      end else if (reload) begin
         cnt_reg <= '0;
         div_reg <= baud_div;
      end else if (cnt_reg == div_reg) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_config.sv
// ---------------------------------------------------------------------------
// uart_config
// Full-duplex UART with compile-time frame format.
//   clk, rst  : clock, asynchronous active-high reset
//   baud_div  : tick period minus one (OVERSAMPLE ticks per bit)
//   rx        : asynchronous serial input, idle high
//   tx        : serial output, idle high
//   bus       : word handshake and status (uart_config_if.slave)
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stops.
// ---------------------------------------------------------------------------
module uart_config
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             rx,
   output logic             tx,
   uart_config_if.slave     bus
);

   localparam int TICK_W = $clog2(2 * OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] STOP_LAST  = TICK_W'(STOP_BITS * OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] VOTE_FIRST = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] VOTE_MID   = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] VOTE_LAST  = TICK_W'(OVERSAMPLE / 2 + 1);
   localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   logic [2:0]           tx_state_reg;
   logic [TICK_W-1:0]    tx_tick_cnt_reg;
   logic [BIT_W-1:0]     tx_bit_cnt_reg;
   logic [DATA_BITS-1:0] tx_shift_reg;
   logic                 tx_par_reg;
   logic                 tx_reg;
   logic                 tx_ready_en_reg;
   logic                 tx_tick;
   logic                 tx_accept;
   logic                 tx_phase_end;

   // tx_ready_en_reg keeps tx_ready low while in reset and lets it rise on
   // the first clock after release (the FSM itself already sits in IDLE).
   assign bus.tx_ready = (tx_state_reg == ST_IDLE) && tx_ready_en_reg;
   assign bus.tx_busy  = (tx_state_reg != ST_IDLE);
   assign tx_accept    = bus.tx_valid && bus.tx_ready;
   assign tx           = tx_reg;
   assign tx_phase_end = tx_tick &&
                         (tx_tick_cnt_reg == ((tx_state_reg == ST_STOP) ? STOP_LAST : TICK_LAST));

   uart_baud_gen #(.DIV_W(DIV_W)) u_tx_baud (
      .clk      (clk),
      .rst      (rst),
      .reload   (tx_accept),
      .baud_div (baud_div),
      .tick     (tx_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_reg    <= ST_IDLE;
         tx_tick_cnt_reg <= '0;
         tx_bit_cnt_reg  <= '0;
         tx_shift_reg    <= '0;
         tx_par_reg      <= 1'b0;
         tx_reg          <= 1'b1;
         tx_ready_en_reg <= 1'b0;
      end else begin
         tx_ready_en_reg <= 1'b1;
         if (tx_state_reg != ST_IDLE && tx_tick)
            tx_tick_cnt_reg <= tx_phase_end ? '0 : tx_tick_cnt_reg + 1'b1;
         case (tx_state_reg)
            ST_IDLE: begin
               if (tx_accept) begin
                  tx_shift_reg    <= bus.tx_data;
                  tx_par_reg      <= parity_bit(9'(bus.tx_data), PARITY);
                  tx_reg          <= 1'b0;
                  tx_tick_cnt_reg <= '0;
                  tx_state_reg    <= ST_START;
               end
            end
            ST_START: begin
               if (tx_phase_end) begin
                  tx_reg         <= tx_shift_reg[0];
                  tx_bit_cnt_reg <= '0;
                  tx_state_reg   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tx_phase_end) begin
                  if (tx_bit_cnt_reg == BIT_LAST) begin
                     if (PARITY != PARITY_NONE) begin
                        tx_reg       <= tx_par_reg;
                        tx_state_reg <= ST_PARITY;
                     end else begin
                        tx_reg       <= 1'b1;
                        tx_state_reg <= ST_STOP;
                     end
                  end else begin
                     tx_bit_cnt_reg <= tx_bit_cnt_reg + 1'b1;
                     tx_shift_reg   <= tx_shift_reg >> 1;
                     tx_reg         <= tx_shift_reg[1];
                  end
               end
            end
            ST_PARITY: begin
               if (tx_phase_end) begin
                  tx_reg       <= 1'b1;
                  tx_state_reg <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (tx_phase_end)
                  tx_state_reg <= ST_IDLE;
            end
            default: begin
               tx_reg       <= 1'b1;
               tx_state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   logic                 rx_meta_reg;
   logic                 rx_sync_reg;
   logic [2:0]           rx_state_reg;
   logic [TICK_W-1:0]    rx_tick_cnt_reg;
   logic [BIT_W-1:0]     rx_bit_cnt_reg;
   logic [DATA_BITS-1:0] rx_shift_reg;
   logic [1:0]           rx_ones_reg;
   logic                 rx_par_reg;
   logic                 rx_tick;
   logic                 rx_start;
   logic                 rx_vote_tick;
   logic                 rx_vote_done;
   logic                 rx_bit_val;
   logic                 rx_bit_end;
   logic                 rx_done;
   logic                 rx_valid_reg;
   logic [DATA_BITS-1:0] rx_data_reg;
   rx_status_t           rx_status_reg;

   // Synchroniser resets high so a reset never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_sync_reg <= rx_meta_reg;
      end
   end

   assign rx_start     = (rx_state_reg == ST_IDLE) && !rx_sync_reg;
   assign rx_vote_tick = rx_tick && (rx_tick_cnt_reg == VOTE_FIRST || rx_tick_cnt_reg == VOTE_MID);
   assign rx_vote_done = rx_tick && (rx_tick_cnt_reg == VOTE_LAST);
   assign rx_bit_end   = rx_tick && (rx_tick_cnt_reg == TICK_LAST);
   // Third sample is combined combinationally so the vote resolves on its tick.
   assign rx_bit_val   = (rx_ones_reg + {1'b0, rx_sync_reg}) >= 2'd2;
   assign rx_done      = (rx_state_reg == ST_STOP) && rx_vote_done;

   uart_baud_gen #(.DIV_W(DIV_W)) u_rx_baud (
      .clk      (clk),
      .rst      (rst),
      .reload   (rx_start),
      .baud_div (baud_div),
      .tick     (rx_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_reg    <= ST_IDLE;
         rx_tick_cnt_reg <= '0;
         rx_bit_cnt_reg  <= '0;
         rx_shift_reg    <= '0;
         rx_ones_reg     <= '0;
         rx_par_reg      <= 1'b0;
      end else begin
         if (rx_state_reg != ST_IDLE && rx_tick) begin
            rx_tick_cnt_reg <= rx_bit_end ? '0 : rx_tick_cnt_reg + 1'b1;
            if (rx_vote_done)
               rx_ones_reg <= '0;
            else if (rx_vote_tick)
               rx_ones_reg <= rx_ones_reg + {1'b0, rx_sync_reg};
         end
         case (rx_state_reg)
            ST_IDLE: begin
               if (rx_start) begin
                  rx_tick_cnt_reg <= '0;
                  rx_ones_reg     <= '0;
                  rx_state_reg    <= ST_START;
               end
            end
            ST_START: begin
               // A start bit that votes high was a glitch: drop it silently.
               if (rx_vote_done && rx_bit_val) begin
                  rx_state_reg <= ST_IDLE;
               end else if (rx_bit_end) begin
                  rx_bit_cnt_reg <= '0;
                  rx_state_reg   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (rx_vote_done)
                  rx_shift_reg <= {rx_bit_val, rx_shift_reg[DATA_BITS-1:1]};
               if (rx_bit_end) begin
                  if (rx_bit_cnt_reg == BIT_LAST)
                     rx_state_reg <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  else
                     rx_bit_cnt_reg <= rx_bit_cnt_reg + 1'b1;
               end
            end
            ST_PARITY: begin
               if (rx_vote_done)
                  rx_par_reg <= rx_bit_val;
               if (rx_bit_end)
                  rx_state_reg <= ST_STOP;
            end
            ST_STOP: begin
               // Leave mid stop bit so a following start edge is not missed.
               if (rx_vote_done)
                  rx_state_reg <= ST_IDLE;
            end
            default: rx_state_reg <= ST_IDLE;
         endcase
      end
   end

   // Output word register: a completing word always wins over consumption.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_valid_reg  <= 1'b0;
         rx_data_reg   <= '0;
         rx_status_reg <= '0;
      end else if (rx_done) begin
         rx_valid_reg             <= 1'b1;
         rx_data_reg              <= rx_shift_reg;
         rx_status_reg.parity_err <= (PARITY != PARITY_NONE) &&
                                     (parity_bit(9'(rx_shift_reg), PARITY) != rx_par_reg);
         rx_status_reg.frame_err  <= !rx_bit_val;
         rx_status_reg.overrun    <= rx_valid_reg && !bus.rx_ready;
      end else if (rx_valid_reg && bus.rx_ready) begin
         rx_valid_reg  <= 1'b0;
         rx_status_reg <= '0;
      end
   end

   assign bus.rx_valid      = rx_valid_reg;
   assign bus.rx_data       = rx_data_reg;
   assign bus.rx_parity_err = rx_status_reg.parity_err;
   assign bus.rx_frame_err  = rx_status_reg.frame_err;
   assign bus.rx_overrun    = rx_status_reg.overrun;
   assign bus.rx_busy       = (rx_state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_config.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_config
// Self-checking bench for uart_config (8 data bits, even parity, 1 stop,
// 16x oversampling, baud_div=3 -> 64 clk per bit). Expected serial frames
// and receive results come from a small frame model built from the frame
// rules (start 0, data LSB first, even parity, stop 1).
// ---------------------------------------------------------------------------
module tb_uart_config;

   localparam int DATA_BITS  = 8;
   localparam int PARITY     = 2;
   localparam int STOP_BITS  = 1;
   localparam int OVERSAMPLE = 16;
   localparam int DIV_W      = 16;
   localparam int BIT_CYC    = 64;
   localparam int FRAME_CYC  = 11 * BIT_CYC;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [DIV_W-1:0] baud_div = 16'd3;
   logic             rx_drv = 1'b1;
   logic             loop_en = 1'b0;
   logic             tx;
   logic             rx_line;

   int vectors = 0;
   int miscompares = 0;

   logic frame_q[$];

   uart_config_if #(.DATA_BITS(DATA_BITS)) bus ();

   assign rx_line = loop_en ? tx : rx_drv;

   uart_config #(
      .DATA_BITS  (DATA_BITS),
      .PARITY     (PARITY),
      .STOP_BITS  (STOP_BITS),
      .OVERSAMPLE (OVERSAMPLE),
      .DIV_W      (DIV_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .baud_div (baud_div),
      .rx       (rx_line),
      .tx       (tx),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference frame: start, data LSB first, even parity over the data, stop.
   task automatic build_frame(input logic [7:0] d, input logic par_inv, input logic stop_val);
      int n;
      n = 0;
      frame_q.delete();
      frame_q.push_back(1'b0);
      for (int i = 0; i < DATA_BITS; i++) begin
         frame_q.push_back(d[i]);
         if (d[i]) n++;
      end
      frame_q.push_back(((n % 2) == 1) ^ par_inv);
      frame_q.push_back(stop_val);
   endtask

   task automatic drive_rx_frame(input logic [7:0] d, input logic par_inv, input logic stop_val);
      build_frame(d, par_inv, stop_val);
      foreach (frame_q[i]) begin
         rx_drv = frame_q[i];
         repeat (BIT_CYC) cyc();
      end
      rx_drv = 1'b1;
   endtask

   task automatic wait_tx_ready(input string tag);
      for (int i = 0; i < 3000 && bus.tx_ready !== 1'b1; i++) cyc();
      vectors++;
      if (bus.tx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_tx_ready_timeout got %b want 1", tag, bus.tx_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) cyc();
      vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", tx); end
      vectors++; if (bus.tx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_tx_ready got %b want 0", bus.tx_ready); end
      vectors++; if (bus.rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got %b want 0", bus.rx_valid); end
      vectors++;
      if ({bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags got %b want 000", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun});
      end
      vectors++;
      if ({bus.tx_busy, bus.rx_busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_busy got %b want 00", {bus.tx_busy, bus.rx_busy});
      end
      rst = 1'b0;
      vectors++; if (bus.tx_ready !== 1'b0) begin miscompares++; $display("FAIL release_tx_ready_early got %b want 0", bus.tx_ready); end
      cyc();
      vectors++; if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL release_tx_ready got %b want 1", bus.tx_ready); end
      $display("reset sequence done");
   endtask

   // Sends one word, checks every bit at mid-bit and the tx_ready return time.
   // change_at > 0 rewrites baud_div that many cycles into the frame.
   task automatic test_tx_frame(input logic [7:0] d, input int change_at);
      int n;
      int ready_at;
      build_frame(d, 1'b0, 1'b1);
      wait_tx_ready("tx");
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      cyc();
      bus.tx_valid = 1'b0;
      vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL tx_start_edge got %b want 0", tx); end
      n = 0;
      ready_at = -1;
      while (n < 2 * FRAME_CYC && ready_at < 0) begin
         cyc();
         n++;
         if (change_at > 0 && n == change_at) baud_div = 16'd7;
         if ((n % BIT_CYC) == BIT_CYC / 2 && (n / BIT_CYC) < frame_q.size()) begin
            vectors++;
            if (tx !== frame_q[n / BIT_CYC]) begin
               miscompares++;
               $display("FAIL tx_bit%0d data %02h got %b want %b", n / BIT_CYC, d, tx, frame_q[n / BIT_CYC]);
            end
         end
         if (bus.tx_ready === 1'b1) ready_at = n;
      end
      baud_div = 16'd3;
      vectors++;
      if (ready_at != FRAME_CYC) begin
         miscompares++;
         $display("FAIL tx_ready_return data %02h got %0d want %0d", d, ready_at, FRAME_CYC);
      end
      $display("tx frame %02h sent, tx_ready after %0d cycles", d, ready_at);
   endtask

   task automatic test_tx();
      test_tx_frame(8'hA5, 0);
      for (int k = 0; k < 2; k++) test_tx_frame(8'($urandom_range(0, 255)), 0);
   endtask

   task automatic test_baud_change();
      test_tx_frame(8'($urandom_range(0, 255)), 100);
   endtask

   task automatic test_loopback();
      logic [7:0] words[$];
      logic       seen;
      words = '{8'h00, 8'hFF, 8'h5A};
      for (int k = 0; k < 3; k++) words.push_back(8'($urandom_range(0, 255)));
      loop_en = 1'b1;
      foreach (words[k]) begin
         wait_tx_ready("loop");
         bus.tx_valid = 1'b1;
         bus.tx_data  = words[k];
         cyc();
         bus.tx_valid = 1'b0;
         seen = 1'b0;
         for (int i = 0; i < 2 * FRAME_CYC && !seen; i++) begin
            cyc();
            if (bus.rx_valid === 1'b1) seen = 1'b1;
         end
         vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL loop_rx_valid data %02h got 0 want 1", words[k]); end
         vectors++; if (bus.rx_data !== words[k]) begin miscompares++; $display("FAIL loop_rx_data got %02h want %02h", bus.rx_data, words[k]); end
         vectors++;
         if ({bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun} !== 3'b000) begin
            miscompares++;
            $display("FAIL loop_flags data %02h got %b want 000", words[k], {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun});
         end
         bus.rx_ready = 1'b1;
         cyc();
         bus.rx_ready = 1'b0;
         vectors++; if (bus.rx_valid !== 1'b0) begin miscompares++; $display("FAIL loop_consume got %b want 0", bus.rx_valid); end
         $display("loopback word %02h received as %02h", words[k], bus.rx_data);
      end
      wait_tx_ready("loop_end");
      loop_en = 1'b0;
      repeat (10) cyc();
   endtask

   task automatic test_errors();
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      drive_rx_frame(d, 1'b1, 1'b1);
      repeat (20) cyc();
      vectors++; if (bus.rx_valid !== 1'b1) begin miscompares++; $display("FAIL par_rx_valid got %b want 1", bus.rx_valid); end
      vectors++; if (bus.rx_data !== d) begin miscompares++; $display("FAIL par_rx_data got %02h want %02h", bus.rx_data, d); end
      vectors++;
      if ({bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun} !== 3'b100) begin
         miscompares++;
         $display("FAIL par_flags got %b want 100", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun});
      end
      bus.rx_ready = 1'b1;
      cyc();
      bus.rx_ready = 1'b0;
      vectors++; if (bus.rx_parity_err !== 1'b0) begin miscompares++; $display("FAIL par_clear got %b want 0", bus.rx_parity_err); end
      $display("rx frame %02h with bad parity", d);

      d = 8'($urandom_range(0, 255));
      drive_rx_frame(d, 1'b0, 1'b0);
      repeat (100) cyc();
      vectors++; if (bus.rx_valid !== 1'b1) begin miscompares++; $display("FAIL stop_rx_valid got %b want 1", bus.rx_valid); end
      vectors++; if (bus.rx_data !== d) begin miscompares++; $display("FAIL stop_rx_data got %02h want %02h", bus.rx_data, d); end
      vectors++;
      if ({bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun} !== 3'b010) begin
         miscompares++;
         $display("FAIL stop_flags got %b want 010", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun});
      end
      bus.rx_ready = 1'b1;
      cyc();
      bus.rx_ready = 1'b0;
      vectors++;
      if ({bus.rx_valid, bus.rx_frame_err} !== 2'b00) begin
         miscompares++;
         $display("FAIL stop_clear got %b want 00", {bus.rx_valid, bus.rx_frame_err});
      end
      $display("rx frame %02h with low stop bit", d);
   endtask

   task automatic test_overrun();
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom_range(0, 255));
      b = a ^ 8'($urandom_range(1, 255));
      drive_rx_frame(a, 1'b0, 1'b1);
      drive_rx_frame(b, 1'b0, 1'b1);
      repeat (10) cyc();
      vectors++; if (bus.rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_rx_valid got %b want 1", bus.rx_valid); end
      vectors++; if (bus.rx_data !== b) begin miscompares++; $display("FAIL ovr_rx_data got %02h want %02h", bus.rx_data, b); end
      vectors++;
      if ({bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun} !== 3'b001) begin
         miscompares++;
         $display("FAIL ovr_flags got %b want 001", {bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun});
      end
      bus.rx_ready = 1'b1;
      cyc();
      bus.rx_ready = 1'b0;
      vectors++;
      if ({bus.rx_valid, bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun} !== 4'b0000) begin
         miscompares++;
         $display("FAIL ovr_clear got %b want 0000", {bus.rx_valid, bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun});
      end
      $display("rx overrun %02h then %02h", a, b);
   endtask

   task automatic test_glitch();
      logic saw_busy;
      logic saw_valid;
      saw_busy  = 1'b0;
      saw_valid = 1'b0;
      rx_drv = 1'b0;
      repeat (20) begin
         cyc();
         if (bus.rx_busy === 1'b1) saw_busy = 1'b1;
      end
      rx_drv = 1'b1;
      repeat (200) begin
         cyc();
         if (bus.rx_busy === 1'b1) saw_busy = 1'b1;
         if (bus.rx_valid === 1'b1) saw_valid = 1'b1;
      end
      vectors++; if (saw_busy !== 1'b1) begin miscompares++; $display("FAIL glitch_start got %b want 1", saw_busy); end
      vectors++; if (saw_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_rx_valid got %b want 0", saw_valid); end
      vectors++; if (bus.rx_busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle got %b want 0", bus.rx_busy); end
      $display("rx glitch of 20 cycles rejected");
   endtask

   task automatic test_reset_mid();
      wait_tx_ready("rstmid");
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h00;
      cyc();
      bus.tx_valid = 1'b0;
      repeat (150) cyc();
      vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rstmid_tx_before got %b want 0", tx); end
      rst = 1'b1;
      #1;
      vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx got %b want 1", tx); end
      vectors++;
      if ({bus.tx_ready, bus.tx_busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL rstmid_ready_busy got %b want 00", {bus.tx_ready, bus.tx_busy});
      end
      cyc();
      rst = 1'b0;
      vectors++; if (bus.tx_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready_early got %b want 0", bus.tx_ready); end
      cyc();
      vectors++; if (bus.tx_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b want 1", bus.tx_ready); end
      $display("reset during transmit handled");
   endtask

   initial begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      bus.rx_ready = 1'b0;
      test_reset();
      test_tx();
      test_baud_change();
      test_loopback();
      test_errors();
      test_overrun();
      test_glitch();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_config.md
UART_CONFIG -- requirements
Module: uart_config

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..9.
REQ-002 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits transmitted, legal 1 or 2.
REQ-004 SHALL have parameter OVERSAMPLE, default 16: baud ticks per bit, even, legal 4..16.
REQ-005 SHALL have parameter DIV_W, default 16: width of baud_div.
REQ-006 SHALL have port clk, input, 1: single clock.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port baud_div, input, DIV_W: tick period minus one, in clk cycles.
REQ-009 SHALL have port rx, input, 1: asynchronous serial in, idle high.
REQ-010 SHALL have port tx, output, 1: serial out, idle high.
REQ-011 SHALL have port tx_valid, input, 1: tx_data is offered.
REQ-012 SHALL have port tx_ready, output, 1: transmitter accepts a word.
REQ-013 SHALL have port tx_data, input, DATA_BITS: word to send, LSB first.
REQ-014 SHALL have port rx_valid, output, 1: rx_data holds an unread word.
REQ-015 SHALL have port rx_ready, input, 1: consumer takes rx_data.
REQ-016 SHALL have port rx_data, output, DATA_BITS: received word.
REQ-017 SHALL have ports rx_parity_err, rx_frame_err and rx_overrun, output, 1 each: status qualified by rx_valid.
REQ-018 SHALL have ports tx_busy and rx_busy, output, 1 each: FSM not idle.

Function
REQ-019 Each direction SHALL own a tick divider that reloads baud_div on frame start and pulses once every baud_div+1 cycles (baud_div=0 gives a tick every cycle).
REQ-020 baud_div SHALL be captured at frame start; changes mid-frame SHALL have no effect until the next frame.
REQ-021 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; each bit lasts exactly OVERSAMPLE ticks.
REQ-022 tx_ready SHALL be high only in TX IDLE; a word is accepted on a cycle with tx_valid && tx_ready, and tx falls low on the next clock edge.
REQ-023 PARITY state SHALL be skipped when PARITY=0; the parity bit SHALL make the total count of ones (data plus parity) odd for PARITY=1 and even for PARITY=2.
REQ-024 TX STOP SHALL hold tx high for STOP_BITS*OVERSAMPLE ticks, then return to IDLE, with tx_ready high on the following cycle.
REQ-025 rx SHALL pass through a two-flop synchroniser, reset high, before any use.
REQ-026 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; a synchronised low in IDLE enters START and restarts the RX divider.
REQ-027 Each bit value SHALL be the majority of samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-028 If the start bit votes high, RX SHALL return to IDLE silently, with no flags set.
REQ-029 RX SHALL check the first stop bit only and return to IDLE right after its mid-bit vote.
REQ-030 When the stop bit is voted, RX SHALL load rx_data, set rx_valid, and set rx_parity_err on mismatch and rx_frame_err if the stop bit voted low.
REQ-031 rx_valid SHALL clear on a cycle with rx_valid && rx_ready, unless a new word completes in that same cycle, in which case the new word loads and rx_valid stays high.
REQ-032 If a word completes while rx_valid is high and rx_ready is low, the new word SHALL overwrite rx_data and rx_overrun SHALL be set.
REQ-033 Error flags SHALL be updated with each loaded word and SHALL clear when that word is consumed.
REQ-034 TX and RX SHALL run independently; simultaneous activity and any relation between baud_div values SHALL be legal.

Reset
REQ-035 During reset: tx=1, tx_ready=0, rx_valid=0, all error flags 0, busy flags 0, both FSMs IDLE, dividers cleared.
REQ-036 Reset asserted mid-frame SHALL abort both directions immediately; tx_ready SHALL rise on the first clock after deassertion.

Structure
REQ-037 Package uart_pkg SHALL hold the parity-mode constants and the TX/RX state encodings.
REQ-038 Sub-module uart_baud_gen (reload, tick output) SHALL be instantiated once per direction.

Verification (DATA_BITS=8, PARITY=2, STOP_BITS=1, OVERSAMPLE=16, baud_div=3, so 64 clk per bit)
REQ-039 Send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,0,1, each 64 cycles; tx_ready returns 704 cycles after acceptance.
REQ-040 Loop tx to rx and send 0x00, 0xFF, 0x5A -> three rx_valid with matching data and all flags 0.
REQ-041 Drive a frame with the parity bit inverted, then a frame with stop=0 -> rx_parity_err=1, then rx_frame_err=1, each with its data.
REQ-042 Receive two frames with rx_ready=0 -> second word present, rx_overrun=1; one rx_ready cycle clears rx_valid and all flags.
REQ-043 Drive a 20-cycle low glitch on rx -> no rx_valid, RX back in IDLE.
REQ-044 Assert rst mid-transmit -> tx=1 at once, and tx_ready=1 on the first clock after release.
